// File: rtl/multi_phase_traffic_controller.sv
// multi_phase_traffic_controller: demand-actuated N-phase signal sequencer with round-robin service; TLC_FLASH_EN adds a flash mode
module multi_phase_traffic_controller #(
  parameter int NUM_PHASES  = 4,
  parameter int CNT_W       = 16,
  parameter int GREEN_MIN   = 1000,
  parameter int GREEN_MAX   = 3000,
  parameter int YELLOW_TIME = 500,
  parameter int ALLRED_TIME = 100,
  parameter int FLASH_HALF  = 250,
  localparam int AW = NUM_PHASES > 2 ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef TLC_FLASH_EN
  input  logic                  flash_req,
`endif
  input  logic [NUM_PHASES-1:0] demand,
  output logic [NUM_PHASES-1:0] phase_red,
  output logic [NUM_PHASES-1:0] phase_yellow,
  output logic [NUM_PHASES-1:0] phase_green,
  output logic [AW-1:0]         active_phase,
  output logic [NUM_PHASES-1:0] pending
);
  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
`ifdef TLC_FLASH_EN
    S_FLASH  = 2'd3,
`endif
    S_ALLRED = 2'd2
  } state_t;
  localparam logic [CNT_W-1:0] GMIN1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL1  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR1   = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] FH1   = CNT_W'(FLASH_HALF - 1);
  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [AW-1:0]         r_active, w_active_nxt, w_rr, w_idx;
  logic [NUM_PHASES-1:0] r_pending, w_pend_nxt, w_oh, w_set, w_clr, w_g, w_y;
  logic                  w_flash, w_fexit, w_flash_on;
`ifdef TLC_FLASH_EN
  logic r_flash_on, r_fexit;
  assign w_flash    = r_state == S_FLASH;
  assign w_fexit    = r_fexit;
  assign w_flash_on = r_flash_on;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_flash_on <= 1'b1;
      r_fexit    <= 1'b0;
    end else begin
      r_flash_on <= !w_flash ? 1'b1 : (r_cnt == FH1 ? ~r_flash_on : r_flash_on);
      r_fexit    <= w_flash ? 1'b1 : (r_state == S_ALLRED ? r_fexit : 1'b0);
    end
`else
  assign w_flash    = 1'b0;
  assign w_fexit    = 1'b0;
  assign w_flash_on = 1'b0;
`endif
  always_comb begin
    w_oh = NUM_PHASES'(1) << r_active;
    w_rr = r_active;
    w_idx = r_active;
    // descending search so the nearest pending phase after the active one wins
    for (int k = NUM_PHASES; k > 0; k--) begin
      w_idx = AW'((int'(r_active) + k) % NUM_PHASES);
      if (r_pending[w_idx]) w_rr = w_idx;
    end
    w_state_nxt = r_state;
    w_active_nxt = r_active;
    case (r_state)
      S_GREEN:  if (r_cnt >= GMIN1 && |(r_pending & ~w_oh) && (r_cnt == GMAX1 || !demand[r_active]))
                  w_state_nxt = S_YELLOW;
      S_YELLOW: if (r_cnt == YEL1) w_state_nxt = S_ALLRED;
      S_ALLRED: if (r_cnt == AR1) begin
                  w_state_nxt = S_GREEN;
                  w_active_nxt = w_fexit ? '0 : w_rr;
                end
`ifdef TLC_FLASH_EN
      S_FLASH:  if (!flash_req) w_state_nxt = S_ALLRED;
`endif
      default:  w_state_nxt = S_ALLRED;
    endcase
`ifdef TLC_FLASH_EN
    if (flash_req) w_state_nxt = S_FLASH;
`endif
    w_set = demand & ~(r_state == S_GREEN ? w_oh : '0);
    w_clr = (w_state_nxt == S_GREEN && r_state != S_GREEN) ? NUM_PHASES'(1) << w_active_nxt : '0;
    w_pend_nxt = w_flash ? r_pending : (r_pending | w_set) & ~w_clr;
    w_cnt_nxt = w_state_nxt != r_state ? '0 :
                (r_state == S_GREEN && r_cnt == GMAX1) ? r_cnt :
                (w_flash && r_cnt == FH1) ? '0 : r_cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= S_GREEN;
      r_cnt     <= '0;
      r_active  <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_active  <= w_active_nxt;
      r_pending <= w_pend_nxt;
    end
  always_comb begin
    w_g = r_state == S_GREEN ? w_oh : '0;
    w_y = r_state == S_YELLOW ? w_oh : (w_flash ? {NUM_PHASES{w_flash_on}} : '0);
  end
  assign phase_green  = w_g;
  assign phase_yellow = w_y;
  assign phase_red    = w_flash ? '0 : ~(w_g | w_y);
  assign active_phase = r_active;
  assign pending      = r_pending;
endmodule
